fifo_frame_unpacker: RTL

- Read-side consumer of the prefetch async FIFO in the capture path.
- Pops c_IN_WIDTH-bit sample words through the FIFO's valid/pop handshake (rd_vld/rd_en).
- Splits each word into c_IN_WIDTH/c_OUT_WIDTH narrower beats and emits them as one framed packet (sof/eof) of a commanded word count to the downstream link/display stage, under a valid/ready handshake.

---
 rtl/fifo_frame_unpacker.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fifo_frame_unpacker.sv
// Pops wide FIFO words and emits each as c_IN_WIDTH/c_OUT_WIDTH narrow beats, framed by sof/eof over a commanded word count.
// Latency: first pop the cycle after start is accepted, first beat the cycle after that pop; sustained 1 beat/cycle.
// Backpressure: out_vld is registered and holds until out_rdy; the next word is popped only as the current one drains.
//
// Ports: clk/rst (sync, active-high); start/frame_len/abort/busy/done control;
//        fifo_data/fifo_vld/fifo_en FIFO read side; out_data/out_vld/out_rdy/out_sof/out_eof beat stream.
module fifo_frame_unpacker #(
    parameter int c_IN_WIDTH  = 32,
    parameter int c_OUT_WIDTH = 8,
    parameter int c_LEN_WIDTH = 16,
    parameter int c_LSB_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [c_LEN_WIDTH-1:0] frame_len,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    input  logic [c_IN_WIDTH-1:0]  fifo_data,
    input  logic                   fifo_vld,
    output logic                   fifo_en,
    output logic [c_OUT_WIDTH-1:0] out_data,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   out_sof,
    output logic                   out_eof
);
    localparam int R      = c_IN_WIDTH / c_OUT_WIDTH;
    localparam int LOG_R  = $clog2(R);
    localparam int LANE_W = (LOG_R > 0) ? LOG_R : 1;
    localparam int BEAT_W = c_LEN_WIDTH + LOG_R;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(R - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [c_IN_WIDTH-1:0]  hold;
    logic                   hold_vld;
    logic [LANE_W-1:0]      lane;
    logic [LANE_W-1:0]      lane_sel;
    logic [c_LEN_WIDTH-1:0] fetch_left;
    logic [BEAT_W-1:0]      beat_left;
    logic                   sof_pend;
    logic                   xfer;
    logic                   last_lane;
    logic                   pop;
    logic [c_OUT_WIDTH-1:0] lanes [R];

    assign xfer      = out_vld & out_rdy;
    assign last_lane = (lane == LAST_LANE);
    assign lane_sel  = (c_LSB_FIRST != 0) ? lane : (LAST_LANE - lane);

    for (genvar g = 0; g < R; g++) begin : g_lane
        assign lanes[g] = hold[g*c_OUT_WIDTH +: c_OUT_WIDTH];
    end

    assign out_data = lanes[lane_sel];
    assign out_vld  = hold_vld;
    assign out_sof  = hold_vld & sof_pend;
    assign out_eof  = hold_vld & (beat_left == BEAT_W'(1));
    assign fifo_en  = pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (frame_len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    // Refill only when hold is empty or its last lane leaves this cycle,
                    // so a word is never overwritten before all its lanes are sent.
                    pop = (fetch_left != '0) & fifo_vld & (~hold_vld | (xfer & last_lane));
                    if (xfer && beat_left == BEAT_W'(1)) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // A reset cycle must not pop: the word would be lost with the cleared hold.
        if (rst) begin
            pop = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold       <= '0;
            hold_vld   <= 1'b0;
            lane       <= '0;
            fetch_left <= '0;
            beat_left  <= '0;
            sof_pend   <= 1'b0;
        end else if (state == S_RUN && abort) begin
            // Partially sent word is dropped; unpopped words stay in the FIFO.
            hold_vld   <= 1'b0;
            lane       <= '0;
            fetch_left <= '0;
            beat_left  <= '0;
            sof_pend   <= 1'b0;
        end else begin
            if (state == S_IDLE && start && frame_len != '0) begin
                fetch_left <= frame_len;
                beat_left  <= BEAT_W'(frame_len) << LOG_R;
                sof_pend   <= 1'b1;
            end else begin
                if (pop) begin
                    fetch_left <= fetch_left - c_LEN_WIDTH'(1);
                end
                if (xfer) begin
                    beat_left <= beat_left - BEAT_W'(1);
                    sof_pend  <= 1'b0;
                end
            end

            if (pop) begin
                hold     <= fifo_data;
                hold_vld <= 1'b1;
                lane     <= '0;
            end else if (xfer) begin
                if (last_lane) begin
                    hold_vld <= 1'b0;
                    lane     <= '0;
                end else begin
                    lane <= lane + LANE_W'(1);
                end
            end
        end
    end
endmodule
